// File: rtl/bsg_store_packer_pkg.sv
// Shared types and helpers for the store-packer arbiter slice.
// Packed commands are {write_not_read, addr, data}; the MSB flags a write.
// packed_is_write takes commands up to 64 bits wide (zero-extend narrower ones).
package bsg_store_packer_pkg;

    typedef enum logic [0:0] {
        e_idle      = 1'b0,
        e_wait_resp = 1'b1
    } bsg_store_packer_arb_state_e;

    localparam int unsigned bsg_store_packer_stale_max_lp = 255;

    // Return the write_not_read bit of a packed command of the given width.
    function automatic logic packed_is_write(input logic [63:0] cmd, input int unsigned width);
        logic [5:0] msb;
        msb = 6'(width - 1);
        return cmd[msb];
    endfunction

endpackage

// File: rtl/bsg_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr_i, cyclically.
// Produces both a one-hot grant and the binary index of the winner.
module bsg_rr_select
    import bsg_store_packer_pkg::*;
#(
    parameter int unsigned num_req_p = 2
) (
    input  logic [num_req_p-1:0]         req_i,
    input  logic [$clog2(num_req_p)-1:0] ptr_i,
    output logic [num_req_p-1:0]         grant_o,
    output logic [$clog2(num_req_p)-1:0] idx_o,
    output logic                         v_o
);

    localparam int unsigned idx_w_lp = $clog2(num_req_p);

    // Scan farthest-first so the requester nearest the pointer overwrites the result last.
    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        v_o     = 1'b0;
        j       = 0;
        for (int k = int'(num_req_p) - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= int'(num_req_p)) begin
                j = j - int'(num_req_p);
            end
            if (req_i[j]) begin
                idx_o = idx_w_lp'(j);
                v_o   = 1'b1;
            end
        end
        grant_o[idx_o] = v_o;
    end

endmodule

// File: rtl/bsg_store_packer_arbiter.sv
// Round-robin arbiter sharing one packed-store link among num_req_p requesters.
// Writes fire and forget; a read blocks all commands until its response returns
// to the requester that issued it.
// Optional feature: define BSG_STORE_PACKER_ARB_TIMEOUT_EN to enable the read
// timeout, the synthetic all-ones response and the stale-response drain.
module bsg_store_packer_arbiter
    import bsg_store_packer_pkg::*;
#(
    parameter int unsigned num_req_p        = 2,
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned timeout_cycles_p = 1024
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic [num_req_p-1:0]              resp_v_o,
    input  logic [num_req_p-1:0]              resp_ready_i,
    output logic [data_width_p-1:0]           data_o,
    output logic                              v_o,
    input  logic                              ready_i,
    input  logic [data_width_p-1:0]           data_i,
    input  logic                              v_i,
    output logic                              ready_o,
    output logic                              timeout_o
);

    localparam int unsigned idx_w_lp = $clog2(num_req_p);

    bsg_store_packer_arb_state_e state_q;
    logic [idx_w_lp-1:0]         rr_ptr_q;
    logic                        lock_q;
    logic [idx_w_lp-1:0]         lock_id_q;
    logic [idx_w_lp-1:0]         owner_q;

    logic [data_width_p-1:0] req_cmd [num_req_p];
    logic [num_req_p-1:0]    eligible;
    logic [num_req_p-1:0]    grant_rr;
    logic [num_req_p-1:0]    grant_sel;
    logic [idx_w_lp-1:0]     sel_rr;
    logic [idx_w_lp-1:0]     sel;
    logic                    sel_v;
    logic [data_width_p-1:0] cmd_sel;
    logic                    cmd_is_write;
    logic                    hs_cmd;
    logic                    hs_resp;

`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
    localparam int unsigned tmo_w_lp = $clog2(timeout_cycles_p + 1);
    logic [tmo_w_lp-1:0] tmo_cnt_q;
    logic [7:0]          stale_cnt_q;
    logic                timeout_q;
    logic                timed_out;
    assign timed_out = (state_q == e_wait_resp) && (tmo_cnt_q == tmo_w_lp'(timeout_cycles_p));
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Unpack requester slices; reads sit out while stale responses are still owed.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
        assign req_cmd[gi] = req_data_i[gi*data_width_p +: data_width_p];
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
        assign eligible[gi] = req_v_i[gi]
            & ((stale_cnt_q == 8'd0) | packed_is_write(64'(req_cmd[gi]), data_width_p));
`else
        assign eligible[gi] = req_v_i[gi];
`endif
    end

    bsg_rr_select #(.num_req_p(num_req_p)) u_rr_select (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_rr),
        .idx_o   (sel_rr),
        .v_o     (sel_v)
    );

    // A stalled grant stays with its requester until the downstream accepts it.
    always_comb begin
        sel       = sel_rr;
        grant_sel = grant_rr;
        if (lock_q) begin
            sel            = lock_id_q;
            grant_sel      = '0;
            grant_sel[lock_id_q] = 1'b1;
        end
    end

    assign cmd_sel      = req_cmd[sel];
    assign cmd_is_write = packed_is_write(64'(cmd_sel), data_width_p);
    assign hs_cmd       = v_o & ready_i;
    assign hs_resp      = v_i & ready_o;

    // Combinational command and response steering; everything but resp_data_o is quiet in reset.
    always_comb begin
        v_o         = 1'b0;
        data_o      = '0;
        req_ready_o = '0;
        resp_v_o    = '0;
        resp_data_o = data_i;
        ready_o     = 1'b0;
        if (reset_n_i) begin
            if (state_q == e_idle) begin
                v_o         = lock_q | sel_v;
                data_o      = cmd_sel;
                req_ready_o = grant_sel & {num_req_p{ready_i}};
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
                ready_o     = (stale_cnt_q != 8'd0);
`endif
            end else begin
                resp_v_o[owner_q] = v_i;
                ready_o           = resp_ready_i[owner_q];
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
                if (timed_out) begin
                    resp_v_o[owner_q] = 1'b1;
                    resp_data_o       = '1;
                    ready_o           = 1'b0;
                end
`endif
            end
        end
    end

    // Arbitration FSM: pointer, grant lock, read ownership and (optionally) timeout bookkeeping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            owner_q   <= '0;
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            stale_cnt_q <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                e_idle: begin
                    if (hs_cmd) begin
                        rr_ptr_q <= (sel == idx_w_lp'(num_req_p - 1)) ? '0 : sel + 1'b1;
                        lock_q   <= 1'b0;
                        if (!cmd_is_write) begin
                            owner_q <= sel;
                            state_q <= e_wait_resp;
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end else if (v_o) begin
                        lock_q    <= 1'b1;
                        lock_id_q <= sel;
                    end
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
                    if ((stale_cnt_q != 8'd0) && v_i) begin
                        stale_cnt_q <= stale_cnt_q - 8'd1;
                    end
`endif
                end
                e_wait_resp: begin
`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
                    if (timed_out) begin
                        if (resp_ready_i[owner_q]) begin
                            state_q   <= e_idle;
                            timeout_q <= 1'b1;
                            if (stale_cnt_q != 8'(bsg_store_packer_stale_max_lp)) begin
                                stale_cnt_q <= stale_cnt_q + 8'd1;
                            end
                        end
                    end else if (hs_resp) begin
                        state_q <= e_idle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`else
                    if (hs_resp) begin
                        state_q <= e_idle;
                    end
`endif
                end
                default: state_q <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_store_packer_arbiter.sv
// Directed testbench for bsg_store_packer_arbiter (2 requesters, 32-bit commands).
// Timeout scenario runs only when BSG_STORE_PACKER_ARB_TIMEOUT_EN is defined.
module tb_bsg_store_packer_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_v;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   resp_data;
    logic [N-1:0]   resp_v;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   dn_data;
    logic           dn_v;
    logic           dn_ready;
    logic [W-1:0]   up_data;
    logic           up_v;
    logic           up_ready;
    logic           tmo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_store_packer_arbiter #(
        .num_req_p        (N),
        .data_width_p     (W),
        .timeout_cycles_p (8)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .req_data_i   (req_data),
        .req_v_i      (req_v),
        .req_ready_o  (req_ready),
        .resp_data_o  (resp_data),
        .resp_v_o     (resp_v),
        .resp_ready_i (resp_ready),
        .data_o       (dn_data),
        .v_o          (dn_v),
        .ready_i      (dn_ready),
        .data_i       (up_data),
        .v_i          (up_v),
        .ready_o      (up_ready),
        .timeout_o    (tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d);
        req_data[i*W +: W] = d;
        req_v[i]           = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset with every input active: only resp_data may be non-zero.
        rst_n      = 1'b0;
        req_data   = '0;
        req_v      = 2'b11;
        dn_ready   = 1'b1;
        up_data    = 32'hDEAD0000;
        up_v       = 1'b1;
        resp_ready = 2'b11;
        #2;
        $display("txn reset");
        check("rst_v_o", 32'(dn_v), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_v", 32'(resp_v), 32'd0);
        check("rst_ready_o", 32'(up_ready), 32'd0);
        check("rst_timeout", 32'(tmo), 32'd0);
        check("rst_data_o", dn_data, 32'd0);
        check("rst_resp_data", resp_data, 32'hDEAD0000);
        req_v = '0; up_v = 1'b0; resp_ready = '0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        tick();

        // Back-to-back writes rotate 0,1,0,1 without bubbles.
        $display("txn write pairs");
        set_req(0, 1'b1, 32'h80001234);
        set_req(1, 1'b1, 32'h80005678);
        #1;
        check("wr_a_v", 32'(dn_v), 32'd1);
        check("wr_a_data", dn_data, 32'h80001234);
        check("wr_a_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b1, 32'h80000AAA);
        #1;
        check("wr_b_data", dn_data, 32'h80005678);
        check("wr_b_rdy", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b1, 32'h80000BBB);
        #1;
        check("wr_c_data", dn_data, 32'h80000AAA);
        check("wr_c_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 32'h0);
        #1;
        check("wr_d_data", dn_data, 32'h80000BBB);
        check("wr_d_rdy", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, 32'h0);

        // Read from requester 1; response goes only to it, requester 0 waits.
        $display("txn read r1");
        set_req(1, 1'b1, 32'h00000100);
        #1;
        check("rd_data_o", dn_data, 32'h00000100);
        check("rd_rdy", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, 32'h0);
        set_req(0, 1'b1, 32'h80001111);
        #1;
        check("rd_block_v", 32'(dn_v), 32'd0);
        check("rd_block_rdy", 32'(req_ready), 32'd0);
        check("rd_nresp_v", 32'(resp_v), 32'd0);
        resp_ready = 2'b11; up_data = 32'h000000AB; up_v = 1'b1;
        #1;
        check("rd_resp_v", 32'(resp_v), 32'b10);
        check("rd_resp_data", resp_data, 32'h000000AB);
        check("rd_ready_o", 32'(up_ready), 32'd1);
        tick();
        up_data = 32'h000000CD;
        #1;
        check("post_rd_data", dn_data, 32'h80001111);
        check("post_rd_rdy", 32'(req_ready), 32'b01);
        check("unsol_resp_v", 32'(resp_v), 32'd0);
        check("unsol_ready_o", 32'(up_ready), 32'd0);
        tick();
        set_req(0, 1'b0, 32'h0);
        up_v = 1'b0;

        // Stalled grant to requester 0 locks even though the pointer favours 1.
        $display("txn lock r0");
        dn_ready = 1'b0;
        set_req(0, 1'b1, 32'h80002222);
        #1;
        check("lk0_data", dn_data, 32'h80002222);
        check("lk0_rdy", 32'(req_ready), 32'd0);
        tick();
        set_req(1, 1'b1, 32'h80003333);
        #1;
        check("lk1_data", dn_data, 32'h80002222);
        check("lk1_rdy", 32'(req_ready), 32'd0);
        tick();
        check("lk2_data", dn_data, 32'h80002222);
        dn_ready = 1'b1;
        #1;
        check("lk_acc_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 32'h0);
        #1;
        check("lk_next_data", dn_data, 32'h80003333);
        check("lk_next_rdy", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, 32'h0);

        // Response backpressure holds resp_v and keeps ready_o low.
        $display("txn read r0 backpressure");
        set_req(0, 1'b1, 32'h00000200);
        #1;
        check("bp_rd_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h80004444);
        up_v = 1'b1; up_data = 32'h00000055; resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_resp_v", 32'(resp_v), 32'b01);
            check("bp_ready_o", 32'(up_ready), 32'd0);
            check("bp_v_o", 32'(dn_v), 32'd0);
            tick();
        end
        resp_ready = 2'b01;
        #1;
        check("bp_rel_ready_o", 32'(up_ready), 32'd1);
        check("bp_rel_data", resp_data, 32'h00000055);
        tick();
        up_v = 1'b0;
        #1;
        check("bp_wr_data", dn_data, 32'h80004444);
        check("bp_wr_rdy", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, 32'h0);

        // Async reset in the middle of a read.
        $display("txn reset mid-read");
        set_req(0, 1'b1, 32'h00000300);
        #1;
        check("mr_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 32'h0);
        up_v = 1'b1; up_data = 32'h00000099; resp_ready = 2'b11;
        #1;
        check("mr_resp_v", 32'(resp_v), 32'b01);
        set_req(0, 1'b1, 32'h80005555);
        set_req(1, 1'b1, 32'h80006666);
        rst_n = 1'b0;
        #1;
        check("mr_rst_resp_v", 32'(resp_v), 32'd0);
        check("mr_rst_ready_o", 32'(up_ready), 32'd0);
        check("mr_rst_v_o", 32'(dn_v), 32'd0);
        check("mr_rst_rdy", 32'(req_ready), 32'd0);
        tick();
        up_v = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("mr_post_data", dn_data, 32'h80005555);
        check("mr_post_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 32'h0);
        #1;
        check("mr_post2_data", dn_data, 32'h80006666);
        tick();
        set_req(1, 1'b0, 32'h0);

`ifdef BSG_STORE_PACKER_ARB_TIMEOUT_EN
        // Unanswered read times out after 8 waiting cycles.
        $display("txn read r1 timeout");
        set_req(1, 1'b1, 32'h00000400);
        #1;
        check("to_rd_rdy", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, 32'h0);
        resp_ready = 2'b11;
        n = 0;
        while (resp_v == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 32'd8);
        check("to_resp_v", 32'(resp_v), 32'b10);
        check("to_resp_data", resp_data, 32'hFFFFFFFF);
        check("to_ready_o", 32'(up_ready), 32'd0);
        set_req(0, 1'b1, 32'h00000500);
        tick();
        check("to_pulse", 32'(tmo), 32'd1);
        check("to_drain_ready", 32'(up_ready), 32'd1);
        check("to_rd_blocked", 32'(dn_v), 32'd0);
        tick();
        check("to_pulse_end", 32'(tmo), 32'd0);
        up_v = 1'b1; up_data = 32'h00000077;
        #1;
        check("late_ready_o", 32'(up_ready), 32'd1);
        check("late_resp_v", 32'(resp_v), 32'd0);
        tick();
        check("drained_ready_o", 32'(up_ready), 32'd0);
        check("unblk_data", dn_data, 32'h00000500);
        check("unblk_rdy", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 32'h0);
        #1;
        check("unblk_resp_v", 32'(resp_v), 32'b01);
        tick();
        up_v = 1'b0;
        tick();
`else
        n = 0;
        check("no_timeout", 32'(tmo), 32'(n));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
